// File: rtl/vga_timing_driver.sv
// 640x480@60 VGA timing generator with downscaled (4x4 block) pixel coordinates.
// Sync and blank are delayed to line up with the color returned by the pixel pipeline.
module vga_timing_driver #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 2
) (
    input  logic       VGA_CLK,
    input  logic       reset,
    input  logic [2:0] color,
    output logic [7:0] xvga,
    output logic [6:0] yvga,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] H_SS       = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SE       = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] V_SS       = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SE       = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       h_vis;
    logic       v_vis;
    logic       active;
    logic       hs_n;
    logic       vs_n;

    logic [PIPE_DELAY-1:0] active_pipe;
    logic [PIPE_DELAY-1:0] hs_pipe;
    logic [PIPE_DELAY-1:0] vs_pipe;
    logic                  active_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == H_LAST) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
        end else begin
            hcount <= hcount + 10'd1;
        end
    end

    // NOTE: always_comb assigns every output on every path, so no latch can be inferred.
    always_comb begin
        h_vis  = hcount < H_VIS;
        v_vis  = vcount < V_VIS;
        active = h_vis && v_vis;
        hs_n   = !((hcount >= H_SS) && (hcount < H_SE));
        vs_n   = !((vcount >= V_SS) && (vcount < V_SE));
        xvga   = h_vis ? hcount[9:2] : 8'd0;
        yvga   = v_vis ? vcount[8:2] : 7'd0;
    end

    // NOTE: the delay line is reset to idle so no pre-reset timing or color leaks to the pins.
    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            active_pipe <= '0;
            hs_pipe     <= '1;
            vs_pipe     <= '1;
        end else begin
            active_pipe[0] <= active;
            hs_pipe[0]     <= hs_n;
            vs_pipe[0]     <= vs_n;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                active_pipe[i] <= active_pipe[i-1];
                hs_pipe[i]     <= hs_pipe[i-1];
                vs_pipe[i]     <= vs_pipe[i-1];
            end
        end
    end

    assign active_d = active_pipe[PIPE_DELAY-1];

    // Color is gated by the delayed active, so blanking never shows the input.
    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= 8'h00;
            VGA_G       <= 8'h00;
            VGA_B       <= 8'h00;
            frame_tick  <= 1'b0;
        end else begin
            VGA_HS      <= hs_pipe[PIPE_DELAY-1];
            VGA_VS      <= vs_pipe[PIPE_DELAY-1];
            VGA_BLANK_N <= active_d;
            VGA_R       <= active_d ? {8{color[2]}} : 8'h00;
            VGA_G       <= active_d ? {8{color[1]}} : 8'h00;
            VGA_B       <= active_d ? {8{color[0]}} : 8'h00;
            frame_tick  <= (hcount == 10'd0) && (vcount == V_VIS);
        end
    end

endmodule
